// File: rtl/seg_pkg.sv
// Shared constants for the hex entry/display path: segment LUT, blank code, buffer modes.
package seg_pkg;

   localparam logic [7:0] SEG_BLANK = 8'hFF;

   localparam int MODE_FILL  = 0;
   localparam int MODE_SHIFT = 1;

   // Active-low segments, bit7 = dp (kept off), bits6..0 = g..a
   localparam logic [7:0] HEX_SEG [16] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
   };

   function automatic logic [7:0] hex_to_seg(input logic [3:0] digit);
      return HEX_SEG[digit];
   endfunction

endpackage

// File: rtl/seg_entry_display_if.sv
// Switch/button inputs and display/value outputs of the hex entry block.
interface seg_entry_display_if #(parameter int DIGITS = 8);

   localparam int CNT_W = $clog2(DIGITS + 1);

   logic [3:0]          switches;
   logic                enter;
   logic [DIGITS-1:0]   anodes;
   logic [7:0]          cathodes;
   logic [4*DIGITS-1:0] value;
   logic [CNT_W-1:0]    count;
   logic                full;

   modport master (
      output switches, enter,
      input  anodes, cathodes, value, count, full
   );

   modport slave (
      input  switches, enter,
      output anodes, cathodes, value, count, full
   );

endinterface

// File: rtl/seg_entry_display_debouncer.sv
// Button conditioner: 2-FF synchroniser, stability counter and one-cycle press pulse.
module enter_debouncer #(
   parameter int DEBOUNCE = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic pulse
);

   localparam int CNT_W = $clog2(DEBOUNCE + 1);

   logic             sync_p0;
   logic             sync_p1;
   logic             level;
   logic             armed;
   logic [CNT_W-1:0] stable_cnt;

   // Synchroniser keeps sampling through reset so a button held across reset is seen as high.
   always_ff @(posedge clk) begin
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
   end

   // armed blocks a press that started before reset until the button has been seen released.
   always_ff @(posedge clk) begin
      if (reset) begin
         level      <= 1'b0;
         armed      <= 1'b0;
         stable_cnt <= '0;
         pulse      <= 1'b0;
      end else begin
         pulse <= 1'b0;
         if (!sync_p1)
            armed <= 1'b1;
         if (sync_p1 == level) begin
            stable_cnt <= '0;
         end else if (stable_cnt == CNT_W'(DEBOUNCE - 1)) begin
            level      <= sync_p1;
            stable_cnt <= '0;
            pulse      <= sync_p1 & armed;
         end else begin
            stable_cnt <= stable_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/seg_entry_display.sv
// Hex digit entry buffer with multiplexed 7-segment display.
// Optional macro SEG_ENTRY_BLANK_EN blanks digits that have not been entered yet.
module seg_entry_display
   import seg_pkg::*;
#(
   parameter int DIGITS     = 8,
   parameter int DEBOUNCE   = 16,
   parameter int CLK_DIV    = 100000,
   parameter int SHIFT_MODE = MODE_FILL
) (
   input  logic                clk100mhz,
   input  logic                reset,
   seg_entry_display_if.slave  bus
);

   localparam int VAL_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(DIGITS + 1);
   localparam int IDX_W = $clog2(DIGITS);
   localparam int DIV_W = $clog2(CLK_DIV);

   logic              push;
   logic [VAL_W-1:0]  value_r;
   logic [CNT_W-1:0]  count_r;
   logic              full_w;
   logic [DIV_W-1:0]  div_r;
   logic [IDX_W-1:0]  idx_r;
   logic [3:0]        cur_digit;
   logic [DIGITS-1:0] an_next;
   logic [7:0]        cat_next;
   logic [DIGITS-1:0] anodes_r;
   logic [7:0]        cathodes_r;

   enter_debouncer #(
      .DEBOUNCE (DEBOUNCE)
   ) u_enter (
      .clk   (clk100mhz),
      .reset (reset),
      .btn   (bus.enter),
      .pulse (push)
   );

   assign full_w = (count_r == CNT_W'(DIGITS));

   // Newest digit enters at the bottom; a full buffer only moves in shift mode.
   always_ff @(posedge clk100mhz) begin
      if (reset) begin
         value_r <= '0;
         count_r <= '0;
      end else if (push) begin
         if (!full_w) begin
            value_r <= {value_r[VAL_W-5:0], bus.switches};
            count_r <= count_r + 1'b1;
         end else if (SHIFT_MODE == MODE_SHIFT) begin
            value_r <= {value_r[VAL_W-5:0], bus.switches};
         end
      end
   end

   always_ff @(posedge clk100mhz) begin
      if (reset) begin
         div_r <= '0;
         idx_r <= '0;
      end else if (div_r == DIV_W'(CLK_DIV - 1)) begin
         div_r <= '0;
         idx_r <= (idx_r == IDX_W'(DIGITS - 1)) ? '0 : idx_r + 1'b1;
      end else begin
         div_r <= div_r + 1'b1;
      end
   end

   always_comb begin
      an_next        = '1;
      an_next[idx_r] = 1'b0;
      cur_digit      = value_r[{idx_r, 2'b00} +: 4];
`ifdef SEG_ENTRY_BLANK_EN
      cat_next = (CNT_W'(idx_r) >= count_r) ? SEG_BLANK : hex_to_seg(cur_digit);
`else
      cat_next = hex_to_seg(cur_digit);
`endif
   end

   // Display drive is registered so the pins change one cycle after the scan index.
   always_ff @(posedge clk100mhz) begin
      if (reset) begin
         anodes_r   <= '1;
         cathodes_r <= SEG_BLANK;
      end else begin
         anodes_r   <= an_next;
         cathodes_r <= cat_next;
      end
   end

   assign bus.anodes   = anodes_r;
   assign bus.cathodes = cathodes_r;
   assign bus.value    = value_r;
   assign bus.count    = count_r;
   assign bus.full     = full_w;

endmodule

// File: tb/tb_seg_entry_display.sv
// Bench for seg_entry_display: fill-mode and shift-mode instances against a behavioural model.
module tb_seg_entry_display;

   localparam int DIGITS   = 4;
   localparam int DEBOUNCE = 4;
   localparam int CLK_DIV  = 4;
`ifdef SEG_ENTRY_BLANK_EN
   localparam logic [7:0] UNENTERED = 8'hFF;
`else
   localparam logic [7:0] UNENTERED = 8'hC0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       enter;
   logic [3:0] sw;
   int         n_tests = 0;
   int         n_fail  = 0;

   logic [7:0] lut [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                           8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   always #5 clk = ~clk;

   seg_entry_display_if #(.DIGITS(DIGITS)) bus0 ();
   seg_entry_display_if #(.DIGITS(DIGITS)) bus1 ();

   assign bus0.switches = sw;
   assign bus0.enter    = enter;
   assign bus1.switches = sw;
   assign bus1.enter    = enter;

   seg_entry_display #(.DIGITS(DIGITS), .DEBOUNCE(DEBOUNCE), .CLK_DIV(CLK_DIV), .SHIFT_MODE(0))
      dut0 (.clk100mhz(clk), .reset(reset), .bus(bus0.slave));
   seg_entry_display #(.DIGITS(DIGITS), .DEBOUNCE(DEBOUNCE), .CLK_DIV(CLK_DIV), .SHIFT_MODE(1))
      dut1 (.clk100mhz(clk), .reset(reset), .bus(bus1.slave));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: press is accepted once the synchronised level has held DEBOUNCE samples.
   logic [15:0] m_val0, m_val1;
   int          m_cnt;
   logic [3:0]  exp_an;
   logic [7:0]  exp_cat0, exp_cat1;
   bit          mvalid = 0;
   int          n_edge;
   bit          deb, armed, pend;
   bit          win[$];
   bit          ehist[$];

   always @(posedge clk) begin
      bit s2, all_diff;
      int idx;
      s2 = (ehist.size() >= 2) ? ehist[ehist.size()-2] : 1'b0;
      ehist.push_back(enter);
      if (ehist.size() > 4) void'(ehist.pop_front());
      if (reset) begin
         mvalid = 1; n_edge = 0;
         m_val0 = 0; m_val1 = 0; m_cnt = 0;
         deb = 0; armed = 0; pend = 0; win.delete();
         exp_an = 4'hF; exp_cat0 = 8'hFF; exp_cat1 = 8'hFF;
      end else begin
         n_edge++;
         idx = ((n_edge - 1) / CLK_DIV) % DIGITS;
         exp_an = ~(4'(1) << idx);
         exp_cat0 = lut[(m_val0 >> (4*idx)) & 16'hF];
         exp_cat1 = lut[(m_val1 >> (4*idx)) & 16'hF];
`ifdef SEG_ENTRY_BLANK_EN
         if (idx >= m_cnt) begin exp_cat0 = 8'hFF; exp_cat1 = 8'hFF; end
`endif
         if (pend) begin
            if (m_cnt < DIGITS) m_val0 = {m_val0[11:0], sw};
            m_val1 = {m_val1[11:0], sw};
            if (m_cnt < DIGITS) m_cnt++;
         end
         win.push_back(s2);
         if (win.size() > DEBOUNCE) void'(win.pop_front());
         pend = 0;
         if (win.size() == DEBOUNCE) begin
            all_diff = 1;
            foreach (win[i]) if (win[i] == deb) all_diff = 0;
            if (all_diff) begin
               deb = ~deb;
               win.delete();
               pend = deb && armed;
            end
         end
         if (!s2) armed = 1;
      end
   end

   always @(negedge clk) begin
      if (mvalid) begin
         chk("anodes0",   bus0.anodes,   exp_an);
         chk("cathodes0", bus0.cathodes, exp_cat0);
         chk("value0",    bus0.value,    m_val0);
         chk("count0",    bus0.count,    m_cnt);
         chk("full0",     bus0.full,     m_cnt == DIGITS);
         chk("anodes1",   bus1.anodes,   exp_an);
         chk("cathodes1", bus1.cathodes, exp_cat1);
         chk("value1",    bus1.value,    m_val1);
         chk("count1",    bus1.count,    m_cnt);
         chk("full1",     bus1.full,     m_cnt == DIGITS);
      end
   end

   task automatic do_reset();
      @(negedge clk); reset = 1; enter = 0;
      repeat (3) @(negedge clk);
      reset = 0;
      repeat (3) @(negedge clk);
   endtask

   task automatic press(input logic [3:0] d);
      @(negedge clk); sw = d; enter = 1;
      repeat (10) @(negedge clk);
      enter = 0;
      repeat (10) @(negedge clk);
   endtask

   initial begin
      bit found;
      reset = 1; enter = 0; sw = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_anodes", bus0.anodes, 4'hF);
      chk("rst_cathodes", bus0.cathodes, 8'hFF);
      chk("rst_value", bus0.value, 16'h0000);
      chk("rst_count", bus0.count, 0);
      chk("rst_full", bus0.full, 0);
      @(negedge clk); reset = 0;
      repeat (3) @(negedge clk);

      // Push latency: value changes on the 7th edge after enter is first sampled high.
      sw = 4'h3; enter = 1;
      for (int k = 1; k <= 7; k++) begin
         @(posedge clk); #1;
         if (k == 6) chk("lat_before", bus0.value, 16'h0000);
         if (k == 7) begin
            chk("lat_value", bus0.value, 16'h0003);
            chk("lat_count", bus0.count, 1);
         end
      end
      repeat (13) @(negedge clk);
      enter = 0;
      repeat (10) @(negedge clk);
      chk("held_one_push", bus0.count, 1);

      enter = 1;
      repeat (2) @(negedge clk);
      enter = 0;
      repeat (12) @(negedge clk);
      chk("short_value", bus0.value, 16'h0003);
      chk("short_count", bus0.count, 1);

      // Scan sequence with two digits entered.
      do_reset();
      press(4'h3);
      press(4'h4);
      chk("scan_value", bus0.value, 16'h0034);
      found = 0;
      for (int k = 0; k < 40 && !found; k++) begin
         @(negedge clk);
         if (bus0.anodes == 4'b1110) found = 1;
      end
      chk("scan_found", found, 1);
      chk("scan_cat0", bus0.cathodes, 8'h99);
      repeat (CLK_DIV) @(negedge clk);
      chk("scan_an1", bus0.anodes, 4'b1101);
      chk("scan_cat1", bus0.cathodes, 8'hB0);
      repeat (CLK_DIV) @(negedge clk);
      chk("scan_an2", bus0.anodes, 4'b1011);
      chk("scan_cat2", bus0.cathodes, UNENTERED);
      repeat (CLK_DIV) @(negedge clk);
      chk("scan_an3", bus0.anodes, 4'b0111);
      chk("scan_cat3", bus0.cathodes, UNENTERED);

      // Overfill: fill-and-stop versus shift.
      do_reset();
      for (int d = 1; d <= 5; d++) press(4'(d));
      chk("fill_value", bus0.value, 16'h1234);
      chk("fill_count", bus0.count, 4);
      chk("fill_full", bus0.full, 1);
      chk("shift_value", bus1.value, 16'h2345);
      chk("shift_count", bus1.count, 4);

      // Reset in the middle of a debounce with the button held.
      do_reset();
      sw = 4'h9; enter = 1;
      repeat (3) @(negedge clk);
      reset = 1;
      repeat (2) @(negedge clk);
      reset = 0;
      repeat (20) @(negedge clk);
      chk("rstmid_value", bus0.value, 16'h0000);
      chk("rstmid_count", bus0.count, 0);
      enter = 0;
      repeat (10) @(negedge clk);
      press(4'h9);
      chk("rstmid_repress", bus0.value, 16'h0009);

      // Random button activity and occasional resets, checked every cycle by the model.
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         sw    = 4'($urandom_range(0, 15));
         enter = 1'($urandom_range(0, 1));
         reset = ($urandom_range(0, 40) == 0);
         repeat ($urandom_range(0, 10)) @(negedge clk);
      end
      @(negedge clk); reset = 0; enter = 0;
      repeat (30) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
